// File: rtl/stopwatch_ctrl.sv
// Sequencing controller for the mm:ss stopwatch: start/pause/lap FSM, 100 Hz -> 1 Hz prescaler, lap-split display mux.
// Optional feature macro: OVF_STOP_EN (stop and flag on 59:59 rollover instead of wrapping).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | stopped at zero, prescaler held cleared
// S_RUN   | counting, live time displayed
// S_LAP   | counting, frozen lap split displayed
// S_PAUSE | counting frozen, prescaler phase held
module stopwatch_ctrl #(
    parameter int          TICK_DIV = 100,
    parameter logic [3:0]  LAP_MAX  = 4'd9
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start_p,
    input  logic       i_lap_p,
    input  logic       i_base_tick,
    input  logic [3:0] i_sec0,
    input  logic [3:0] i_sec1,
    input  logic [3:0] i_min0,
    input  logic [3:0] i_min1,
    output logic       o_cnt_en,
    output logic       o_cnt_clr,
    output logic [3:0] o_dig0,
    output logic [3:0] o_dig1,
    output logic [3:0] o_dig2,
    output logic [3:0] o_dig3,
    output logic [1:0] o_state,
    output logic [3:0] o_lap_cnt,
    output logic       o_ovf
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          r_cnt_clr;
    logic [3:0]    r_lap_sec0;
    logic [3:0]    r_lap_sec1;
    logic [3:0]    r_lap_min0;
    logic [3:0]    r_lap_min1;
    logic [3:0]    r_lap_cnt;
    logic          w_counting;
    logic          w_pre_wrap;
    logic          w_evt;
    logic          w_ovf_evt;
    logic          w_ovf;
    logic          w_clr;
    logic          w_lap_take;

    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_pre_wrap = (r_presc == PW'(TICK_DIV - 1));
    assign w_evt      = w_pre_wrap & i_base_tick & w_counting;

`ifdef OVF_STOP_EN
    logic r_ovf;
    logic w_at_max;

    assign w_at_max  = (i_sec0 == 4'd9) && (i_sec1 == 4'd5) &&
                       (i_min0 == 4'd9) && (i_min1 == 4'd5);
    assign w_ovf_evt = w_evt & w_at_max;
    assign w_ovf     = r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_clr) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end
    end
`else
    assign w_ovf_evt = 1'b0;
    assign w_ovf     = 1'b0;
`endif

    assign o_cnt_en = w_evt & ~w_ovf_evt;

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_lap_take  = 1'b0;
        if (w_ovf_evt) begin
            w_state_nxt = S_PAUSE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start_p) begin
                        w_state_nxt = S_RUN;
                    end else if (i_lap_p) begin
                        w_clr = 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_start_p) begin
                        w_state_nxt = S_PAUSE;
                    end else if (i_lap_p) begin
                        w_state_nxt = S_LAP;
                        w_lap_take  = 1'b1;
                    end
                end
                S_LAP: begin
                    if (i_start_p) begin
                        w_state_nxt = S_PAUSE;
                    end else if (i_lap_p) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_PAUSE: begin
                    // An overflow stop can only be left through a clear.
                    if (i_start_p) begin
                        if (!w_ovf) begin
                            w_state_nxt = S_RUN;
                        end
                    end else if (i_lap_p) begin
                        w_state_nxt = S_IDLE;
                        w_clr       = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_presc_nxt = r_presc;
        if (w_clr || (r_state == S_IDLE)) begin
            w_presc_nxt = '0;
        end else if (w_counting && i_base_tick) begin
            w_presc_nxt = w_pre_wrap ? '0 : r_presc + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_cnt_clr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_cnt_clr <= w_clr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr) begin
            r_lap_sec0 <= 4'd0;
            r_lap_sec1 <= 4'd0;
            r_lap_min0 <= 4'd0;
            r_lap_min1 <= 4'd0;
            r_lap_cnt  <= 4'd0;
        end else if (w_lap_take) begin
            r_lap_sec0 <= i_sec0;
            r_lap_sec1 <= i_sec1;
            r_lap_min0 <= i_min0;
            r_lap_min1 <= i_min1;
            if (r_lap_cnt < LAP_MAX) begin
                r_lap_cnt <= r_lap_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        if (r_state == S_LAP) begin
            o_dig0 = r_lap_sec0;
            o_dig1 = r_lap_sec1;
            o_dig2 = r_lap_min0;
            o_dig3 = r_lap_min1;
        end else begin
            o_dig0 = i_sec0;
            o_dig1 = i_sec1;
            o_dig2 = i_min0;
            o_dig3 = i_min1;
        end
    end

    assign o_cnt_clr = r_cnt_clr;
    assign o_state   = r_state;
    assign o_lap_cnt = r_lap_cnt;
    assign o_ovf     = w_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl; expected values are hand-derived from the stopwatch behaviour.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_p = 1'b0;
    logic       lap_p = 1'b0;
    logic       base_tick = 1'b0;
    logic [3:0] sec0 = 4'd0;
    logic [3:0] sec1 = 4'd0;
    logic [3:0] min0 = 4'd0;
    logic [3:0] min1 = 4'd0;
    logic       cnt_en;
    logic       cnt_clr;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [1:0] state;
    logic [3:0] lap_cnt;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int en_seen = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start_p   (start_p),
        .i_lap_p     (lap_p),
        .i_base_tick (base_tick),
        .i_sec0      (sec0),
        .i_sec1      (sec1),
        .i_min0      (min0),
        .i_min1      (min1),
        .o_cnt_en    (cnt_en),
        .o_cnt_clr   (cnt_clr),
        .o_dig0      (dig0),
        .o_dig1      (dig1),
        .o_dig2      (dig2),
        .o_dig3      (dig3),
        .o_state     (state),
        .o_lap_cnt   (lap_cnt),
        .o_ovf       (ovf)
    );

    // One clock with the given pulses; cnt_en is sampled mid-cycle, outputs are stable 1 ns after the edge.
    task automatic cyc(input logic st, input logic lp, input logic bt);
        start_p   = st;
        lap_p     = lp;
        base_tick = bt;
        #1;
        if (cnt_en === 1'b1) en_seen++;
        @(posedge clk);
        #1;
        start_p   = 1'b0;
        lap_p     = 1'b0;
        base_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        sec0 = 4'd1; sec1 = 4'd2; min0 = 4'd3; min1 = 4'd4;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL reset_cnt_clr got=%b exp=0", cnt_clr); end
        checks++; if (lap_cnt !== 4'd0) begin errors++; $display("FAIL reset_lap_cnt got=%0d exp=0", lap_cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL reset_cnt_en got=%b exp=0", cnt_en); end
        checks++;
        if ({dig3, dig2, dig1, dig0} !== 16'h4321) begin
            errors++; $display("FAIL reset_digits got=%h exp=4321", {dig3, dig2, dig1, dig0});
        end
        rst = 1'b0;
        sec0 = 4'd0; sec1 = 4'd0; min0 = 4'd0; min1 = 4'd0;
    endtask

    task automatic test_prescale;
        int n_en;
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state got=%0d exp=1", state); end
        n_en = 0;
        for (int i = 1; i <= 300; i++) begin
            base_tick = 1'b1;
            #1;
            checks++;
            if (cnt_en !== ((i % 100) == 0)) begin
                errors++; $display("FAIL presc_cnt_en tick=%0d got=%b exp=%b", i, cnt_en, ((i % 100) == 0));
            end
            if (cnt_en === 1'b1) n_en++;
            @(posedge clk);
            #1;
            base_tick = 1'b0;
        end
        checks++; if (n_en != 3) begin errors++; $display("FAIL presc_total got=%0d exp=3", n_en); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL presc_state got=%0d exp=1", state); end
    endtask

    task automatic test_lap;
        sec0 = 4'd7;
        cyc(1'b0, 1'b1, 1'b0);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL lap_state got=%0d exp=2", state); end
        checks++; if (lap_cnt !== 4'd1) begin errors++; $display("FAIL lap_cnt got=%0d exp=1", lap_cnt); end
        sec0 = 4'd9; sec1 = 4'd1;
        #1;
        checks++;
        if ({dig3, dig2, dig1, dig0} !== 16'h0007) begin
            errors++; $display("FAIL lap_frozen got=%h exp=0007", {dig3, dig2, dig1, dig0});
        end
        en_seen = 0;
        ticks(100);
        checks++; if (en_seen != 1) begin errors++; $display("FAIL lap_counting got=%0d exp=1", en_seen); end
        cyc(1'b0, 1'b1, 1'b0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL lap_release_state got=%0d exp=1", state); end
        checks++;
        if ({dig3, dig2, dig1, dig0} !== 16'h0019) begin
            errors++; $display("FAIL lap_release_digits got=%h exp=0019", {dig3, dig2, dig1, dig0});
        end
    endtask

    task automatic test_pause;
        en_seen = 0;
        ticks(50);
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL pause_state got=%0d exp=3", state); end
        ticks(500);
        checks++; if (en_seen != 0) begin errors++; $display("FAIL pause_hold got=%0d exp=0", en_seen); end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state got=%0d exp=1", state); end
        ticks(50);
        checks++; if (en_seen != 1) begin errors++; $display("FAIL pause_resume_en got=%0d exp=1", en_seen); end
    endtask

    task automatic test_wrap_with_start;
        en_seen = 0;
        ticks(99);
        checks++; if (en_seen != 0) begin errors++; $display("FAIL prewrap_en got=%0d exp=0", en_seen); end
        start_p = 1'b1; base_tick = 1'b1;
        #1;
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL wrap_start_cnt_en got=%b exp=1", cnt_en); end
        @(posedge clk); #1;
        start_p = 1'b0; base_tick = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL wrap_start_state got=%0d exp=3", state); end
    endtask

    task automatic test_back_to_back;
        cyc(1'b1, 1'b1, 1'b0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL both_state got=%0d exp=1", state); end
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL both_cnt_clr got=%b exp=0", cnt_clr); end
        checks++; if (lap_cnt !== 4'd1) begin errors++; $display("FAIL both_lap_cnt got=%0d exp=1", lap_cnt); end
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL clear_pulse got=%b exp=1", cnt_clr); end
        checks++; if (lap_cnt !== 4'd0) begin errors++; $display("FAIL clear_lap_cnt got=%0d exp=0", lap_cnt); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL clear_state got=%0d exp=0", state); end
        cyc(1'b0, 1'b0, 1'b0);
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL clear_width got=%b exp=0", cnt_clr); end
    endtask

    task automatic test_lap_sat;
        int exp_cnt;
        logic was_run;
        exp_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 24; k++) begin
            was_run = ((k % 2) == 0);
            cyc(1'b0, 1'b1, 1'b0);
            if (was_run) exp_cnt = (exp_cnt < 9) ? exp_cnt + 1 : 9;
            checks++;
            if (lap_cnt !== 4'(exp_cnt)) begin
                errors++; $display("FAIL lap_sat press=%0d got=%0d exp=%0d", k, lap_cnt, exp_cnt);
            end
            checks++;
            if (state !== (was_run ? 2'd2 : 2'd1)) begin
                errors++; $display("FAIL lap_sat_state press=%0d got=%0d exp=%0d", k, state, was_run ? 2 : 1);
            end
        end
        sec0 = 4'd3; sec1 = 4'd2; min0 = 4'd1; min1 = 4'd0;
        cyc(1'b0, 1'b1, 1'b0);
        sec0 = 4'd5; sec1 = 4'd4; min0 = 4'd3; min1 = 4'd2;
        #1;
        checks++;
        if ({dig3, dig2, dig1, dig0} !== 16'h0123) begin
            errors++; $display("FAIL lap2_frozen got=%h exp=0123", {dig3, dig2, dig1, dig0});
        end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL lap_to_pause got=%0d exp=3", state); end
        checks++;
        if ({dig3, dig2, dig1, dig0} !== 16'h2345) begin
            errors++; $display("FAIL pause_live_digits got=%h exp=2345", {dig3, dig2, dig1, dig0});
        end
        checks++; if (lap_cnt !== 4'd9) begin errors++; $display("FAIL lap_sat_hold got=%0d exp=9", lap_cnt); end
        cyc(1'b0, 1'b1, 1'b0);
        checks++; if (lap_cnt !== 4'd0) begin errors++; $display("FAIL sat_clear got=%0d exp=0", lap_cnt); end
    endtask

    task automatic test_rst_mid;
        cyc(1'b1, 1'b0, 1'b0);
        ticks(50);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_mid_state got=%0d exp=0", state); end
        cyc(1'b1, 1'b0, 1'b0);
        en_seen = 0;
        ticks(99);
        checks++; if (en_seen != 0) begin errors++; $display("FAIL rst_mid_presc got=%0d exp=0", en_seen); end
        ticks(1);
        checks++; if (en_seen != 1) begin errors++; $display("FAIL rst_mid_wrap got=%0d exp=1", en_seen); end
    endtask

    task automatic test_overflow;
        sec0 = 4'd9; sec1 = 4'd5; min0 = 4'd9; min1 = 4'd5;
        ticks(99);
        base_tick = 1'b1;
        #1;
`ifdef OVF_STOP_EN
        checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL ovf_cnt_en got=%b exp=0", cnt_en); end
        @(posedge clk); #1;
        base_tick = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL ovf_state got=%0d exp=3", state); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL ovf_start_ignored got=%0d exp=3", state); end
        cyc(1'b0, 1'b1, 1'b0);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL ovf_clear_state got=%0d exp=0", state); end
`else
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL wrap5959_cnt_en got=%b exp=1", cnt_en); end
        @(posedge clk); #1;
        base_tick = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL wrap5959_state got=%0d exp=1", state); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap5959_ovf got=%b exp=0", ovf); end
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL wrap5959_clear got=%0d exp=0", state); end
`endif
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_prescale();
        test_lap();
        test_pause();
        test_wrap_with_start();
        test_back_to_back();
        test_lap_sat();
        test_rst_mid();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
